hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL take parameter NREGS, default 32, as the number of architectural registers; register 0 is hardwired zero.
REQ-002 The block SHALL take parameter MUL_EXTRA, default 2, as the multiplier cycles beyond the ALU path, range 0..12.
REQ-003 The block SHALL take parameter CNT_W, default 4, as the countdown counter width, which must hold 3+MUL_EXTRA.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock. One clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port issue_valid, input, 1 bit: the decode stage presents an instruction.
REQ-007 The block SHALL have ports issue_a_reg and issue_b_reg, input, log2(NREGS) bits each: source registers.
REQ-008 The block SHALL have port issue_uses_b, input, 1 bit: the b source is read.
REQ-009 The block SHALL have ports issue_wb_en (input, 1 bit) and issue_wb_reg (input, log2(NREGS) bits): the destination register.
REQ-010 The block SHALL have port issue_class, input, 2 bits: 0 ALU, 1 LOAD, 2 MUL, 3 reserved (treated as ALU).
REQ-011 The block SHALL have port stall, output, 1 bit, combinational: hold PC and decode this cycle.
REQ-012 The block SHALL have ports fwd_a_sel and fwd_b_sel, output, 2 bits each, registered: operand source for the consumer's EX cycle (0 RF, 1 MEM register, 2 WB value, 3 WB_LAST held copy).
REQ-013 The block SHALL have port pending_count, output, log2(NREGS)+1 bits, registered: the number of registers with pending writes.

Function
REQ-014 Each register SHALL have its own entry holding a pending bit, a countdown cnt (CNT_W bits) and its class.
REQ-015 An issue SHALL be accepted when issue_valid=1 and stall=0.
REQ-016 On an accepted issue with issue_wb_en=1 and issue_wb_reg!=0, the entry for issue_wb_reg SHALL load pending=1 and cnt=3 (ALU/LOAD) or cnt=3+MUL_EXTRA (MUL).
REQ-017 On every edge, each pending entry whose load REQ-016 does not override SHALL decrement cnt; when cnt reaches 0, pending SHALL clear.
REQ-018 Counters SHALL keep decrementing while stall=1.
REQ-019 Per-source resolution (source a always; source b only if issue_uses_b=1) SHALL use the entry state before this cycle's update:
  - register 0 or not pending -> 0
  - cnt>=4 -> stall
  - cnt==3 -> 1 if class is ALU or MUL; stall if class is LOAD
  - cnt==2 -> 2
  - cnt==1 -> 3
REQ-020 stall SHALL also assert on a WAW hazard: the destination is pending and the new load value is less than the current cnt.
REQ-021 stall SHALL equal issue_valid AND (any source stall OR WAW hazard), and SHALL be 0 when issue_valid=0.
REQ-022 On an accepted issue, fwd_a_sel and fwd_b_sel SHALL register the resolved values; otherwise they SHALL register 0.
REQ-023 A source register equal to the destination of the same instruction SHALL resolve against the old state.
REQ-024 pending_count SHALL register the population count of pending bits after the update.

Reset
REQ-025 When rst=1 at an edge, all pending bits SHALL clear, all cnt SHALL become 0, fwd_a_sel and fwd_b_sel SHALL become 0, and pending_count SHALL become 0.
REQ-026 Reset mid-operation SHALL discard in-flight entries, and issue_valid SHALL be ignored during that cycle.
REQ-027 In the cycle after reset, stall SHALL be 0 for any input.

Configuration
REQ-028 With macro HAZARD_FORWARDING_EN defined, the block SHALL behave as REQ-019.
REQ-029 Without HAZARD_FORWARDING_EN, any pending source with cnt>=1 SHALL stall, fwd_a_sel and fwd_b_sel SHALL be constant 0, and WAW checking SHALL be unchanged.

Structure
REQ-030 A shared package hazard_pkg SHALL hold the fwd_sel encodings, the issue_class encodings, and the base latency constant 3.
REQ-031 The block SHALL contain one sub-module, sb_entry, holding the per-register pending/cnt/class state and its decrement logic, instantiated NREGS-1 times.

Verification
REQ-032 Back-to-back ALU: issue r3<-ALU, then r5<-r3+r4 -> stall=0 and fwd_a_sel=1 in the next cycle.
REQ-033 Load-use: issue r2<-LOAD, then r6<-r2 -> stall=1 for one cycle, then accept with fwd_a_sel=2.
REQ-034 MUL with MUL_EXTRA=2: issue r7<-MUL, then consumer of r7 -> stall for 2 cycles, then accept with fwd_sel=1.
REQ-035 WAW: issue r8<-MUL, then r8<-ALU -> stall until cnt(r8)<=3, and pending_count stays 1.
REQ-036 Assert rst with 3 entries pending -> pending_count=0 and stall=0 on the following cycle.
REQ-037 Without HAZARD_FORWARDING_EN: issue r3<-ALU, then consumer of r3 -> 3 stall cycles, then fwd_a_sel=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings and base latency for the hazard scoreboard.
// Pure definitions: no state, so no latency or backpressure.
package hazard_pkg;

  localparam int BASE_LAT = 3;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_RSVD = 2'd3
  } issue_class_t;

  typedef enum logic [1:0] {
    FWD_RF      = 2'd0,
    FWD_MEM     = 2'd1,
    FWD_WB      = 2'd2,
    FWD_WB_LAST = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic     stall;
    fwd_sel_t sel;
  } src_res_t;

endpackage

// File: rtl/sb_entry.sv
// One register's pending write: countdown loaded on issue, decremented every edge.
// State visible the cycle after load; has no backpressure of its own.
module sb_entry
  import hazard_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_cnt,
  input  issue_class_t     load_cls,
  output logic             pending,
  output logic [CNT_W-1:0] cnt,
  output issue_class_t     cls,
  output logic             pending_next
);

  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (load) begin
      cnt_next = load_cnt;
    end else if (pending) begin
      cnt_next = cnt - 1'b1;
    end
  end

  assign pending_next = (cnt_next != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      cnt     <= '0;
      cls     <= CLS_ALU;
    end else begin
      pending <= pending_next;
      cnt     <= cnt_next;
      if (load) begin
        cls <= load_cls;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue scoreboard: comb stall; registered fwd selects / pending count one edge after issue.
// Stall holds decode while counters keep draining. HAZARD_FORWARDING_EN enables operand bypass.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter int MUL_EXTRA = 2,
  parameter int CNT_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [$clog2(NREGS)-1:0] issue_a_reg,
  input  logic [$clog2(NREGS)-1:0] issue_b_reg,
  input  logic                     issue_uses_b,
  input  logic                     issue_wb_en,
  input  logic [$clog2(NREGS)-1:0] issue_wb_reg,
  input  logic [1:0]               issue_class,
  output logic                     stall,
  output logic [1:0]               fwd_a_sel,
  output logic [1:0]               fwd_b_sel,
  output logic [$clog2(NREGS):0]   pending_count
);

  localparam int RW = $clog2(NREGS);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_next;
  logic [CNT_W-1:0] cnt   [NREGS];
  issue_class_t     cls   [NREGS];

  logic [CNT_W-1:0] new_cnt;
  logic             wb_live;
  logic             waw;
  logic             accept;
  src_res_t         res_a;
  src_res_t         res_b;
  logic [RW:0]      pop;

  // Register 0 never has a pending write.
  assign pend[0]      = 1'b0;
  assign pend_next[0] = 1'b0;
  assign cnt[0]       = '0;
  assign cls[0]       = CLS_ALU;

  assign new_cnt = (issue_class == CLS_MUL) ? CNT_W'(BASE_LAT + MUL_EXTRA) : CNT_W'(BASE_LAT);
  assign wb_live = issue_wb_en && (issue_wb_reg != '0);

  for (genvar i = 1; i < NREGS; i++) begin : g_entry
    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk          (clk),
      .rst          (rst),
      .load         (accept && wb_live && (issue_wb_reg == RW'(i))),
      .load_cnt     (new_cnt),
      .load_cls     (issue_class_t'(issue_class)),
      .pending      (pend[i]),
      .cnt          (cnt[i]),
      .cls          (cls[i]),
      .pending_next (pend_next[i])
    );
  end

  // cnt counts edges until the producer's value lands in the RF; 3 = in MEM, 2 = in WB, 1 = just written.
  function automatic src_res_t resolve(input logic p, input logic [CNT_W-1:0] c, input issue_class_t k);
    src_res_t r;
    r.stall = 1'b0;
    r.sel   = FWD_RF;
    if (p) begin
      if (c > CNT_W'(BASE_LAT)) begin
        r.stall = 1'b1;
      end else if (c == CNT_W'(BASE_LAT)) begin
        if (k == CLS_LOAD) r.stall = 1'b1;
        else               r.sel   = FWD_MEM;
      end else if (c == CNT_W'(2)) begin
        r.sel = FWD_WB;
      end else begin
        r.sel = FWD_WB_LAST;
      end
    end
`ifdef HAZARD_FORWARDING_EN
    return r;
`else
    // Without bypass any source that would have needed a forward must wait for the RF.
    r.stall = r.stall || (r.sel != FWD_RF);
    r.sel   = FWD_RF;
    return r;
`endif
  endfunction

  assign res_a = resolve(pend[issue_a_reg], cnt[issue_a_reg], cls[issue_a_reg]);
  assign res_b = resolve(pend[issue_b_reg], cnt[issue_b_reg], cls[issue_b_reg]);

  // A younger write must not finish before an older one still in flight.
  assign waw = wb_live && pend[issue_wb_reg] && (new_cnt < cnt[issue_wb_reg]);

  assign stall  = issue_valid && (res_a.stall || (issue_uses_b && res_b.stall) || waw);
  assign accept = issue_valid && !stall;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NREGS; i++) begin
      pop = pop + {{RW{1'b0}}, pend_next[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_sel     <= FWD_RF;
      fwd_b_sel     <= FWD_RF;
      pending_count <= '0;
    end else begin
      fwd_a_sel     <= accept ? res_a.sel : FWD_RF;
      fwd_b_sel     <= (accept && issue_uses_b) ? res_b.sel : FWD_RF;
      pending_count <= pop;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: directed hazard scenarios plus random issue streams against a timestamp model.
module tb_hazard_scoreboard;

  localparam int NREGS     = 32;
  localparam int MUL_EXTRA = 2;
  localparam int CNT_W     = 4;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int B2B_STALLS = FWD ? 0 : 3;
  localparam int B2B_SEL    = FWD ? 1 : 0;
  localparam int LU_STALLS  = FWD ? 1 : 3;
  localparam int LU_SEL     = FWD ? 2 : 0;
  localparam int MUL_STALLS = FWD ? MUL_EXTRA : 3 + MUL_EXTRA;
  localparam int MUL_SEL    = FWD ? 1 : 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0;
  logic [4:0] issue_a_reg = '0;
  logic [4:0] issue_b_reg = '0;
  logic       issue_uses_b = 1'b0;
  logic       issue_wb_en = 1'b0;
  logic [4:0] issue_wb_reg = '0;
  logic [1:0] issue_class = '0;
  logic       stall;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic [5:0] pending_count;

  hazard_scoreboard #(.NREGS(NREGS), .MUL_EXTRA(MUL_EXTRA), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_a_reg   (issue_a_reg),
    .issue_b_reg   (issue_b_reg),
    .issue_uses_b  (issue_uses_b),
    .issue_wb_en   (issue_wb_en),
    .issue_wb_reg  (issue_wb_reg),
    .issue_class   (issue_class),
    .stall         (stall),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .pending_count (pending_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each register remembers the edge index at which its result is architecturally written.
  int done_at [NREGS];
  int cls_of  [NREGS];
  int now     = 0;
  int exp_a   = 0;
  int exp_b   = 0;
  int exp_cnt = 0;

  function automatic int rem(input int r);
    int d;
    d = done_at[r] - now;
    return (r == 0 || d < 0) ? 0 : d;
  endfunction

  function automatic int lat(input int c);
    return (c == 2) ? 3 + MUL_EXTRA : 3;
  endfunction

  function automatic void resolve(input int r, output bit st, output int sel);
    int c;
    c = rem(r);
    st = 1'b0;
    sel = 0;
    if (c > 0) begin
      if (!FWD)             st = 1'b1;
      else if (c >= 4)      st = 1'b1;
      else if (c == 3)      begin if (cls_of[r] == 1) st = 1'b1; else sel = 1; end
      else if (c == 2)      sel = 2;
      else                  sel = 3;
    end
  endfunction

  function automatic bit model_stall();
    bit sa, sb, waw;
    int fa, fb, w;
    resolve(int'(issue_a_reg), sa, fa);
    resolve(int'(issue_b_reg), sb, fb);
    w = int'(issue_wb_reg);
    waw = issue_wb_en && (w != 0) && (rem(w) > 0) && (lat(int'(issue_class)) < rem(w));
    return issue_valid && (sa || (issue_uses_b && sb) || waw);
  endfunction

  task automatic tick();
    bit sa, sb, acc;
    int fa, fb;
    resolve(int'(issue_a_reg), sa, fa);
    resolve(int'(issue_b_reg), sb, fb);
    acc = issue_valid && !model_stall();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREGS; i++) done_at[i] = 0;
      exp_a = 0;
      exp_b = 0;
    end else begin
      exp_a = acc ? fa : 0;
      exp_b = (acc && issue_uses_b) ? fb : 0;
      if (acc && issue_wb_en && issue_wb_reg != 0) begin
        done_at[issue_wb_reg] = now + lat(int'(issue_class)) + 1;
        cls_of[issue_wb_reg]  = int'(issue_class);
      end
    end
    now++;
    exp_cnt = 0;
    for (int i = 1; i < NREGS; i++) if (rem(i) > 0) exp_cnt++;
    #1;
  endtask

  task automatic drive(input bit v, input int a, input int b, input bit ub,
                       input bit we, input int wr, input int c);
    issue_valid  = v;
    issue_a_reg  = 5'(a);
    issue_b_reg  = 5'(b);
    issue_uses_b = ub;
    issue_wb_en  = we;
    issue_wb_reg = 5'(wr);
    issue_class  = 2'(c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_a got %0d want 0", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_b got %0d want 0", fwd_b_sel); end
    n_checks++; if (pending_count !== 6'd0) begin n_fail++; $display("FAIL reset_pending got %0d want 0", pending_count); end
    drive(1, 7, 9, 1, 1, 7, 2);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 1, 2, 0, 1, 3, 0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_producer_stall got %b want 0", stall); end
    tick();
    n_checks++; if (pending_count !== 6'd1) begin n_fail++; $display("FAIL b2b_pending got %0d want 1", pending_count); end
    drive(1, 3, 4, 1, 1, 5, 0);
    for (int i = 0; i < B2B_STALLS; i++) begin
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_wait_stall cycle %0d got %b want 1", i, stall); end
      tick();
    end
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_consumer_stall got %b want 0", stall); end
    tick();
    n_checks++; if (fwd_a_sel !== 2'(B2B_SEL)) begin n_fail++; $display("FAIL b2b_fwd_a got %0d want %0d", fwd_a_sel, B2B_SEL); end
    n_checks++; if (fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL b2b_fwd_b got %0d want 0", fwd_b_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 1, 2, 1);
    tick();
    drive(1, 2, 0, 0, 1, 6, 0);
    for (int i = 0; i < LU_STALLS; i++) begin
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall cycle %0d got %b want 1", i, stall); end
      tick();
      n_checks++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL load_use_fwd_while_stalled got %0d want 0", fwd_a_sel); end
    end
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_accept got stall %b want 0", stall); end
    tick();
    n_checks++; if (fwd_a_sel !== 2'(LU_SEL)) begin n_fail++; $display("FAIL load_use_fwd_a got %0d want %0d", fwd_a_sel, LU_SEL); end
  endtask

  task automatic test_mul();
    do_reset();
    drive(1, 0, 0, 0, 1, 7, 2);
    tick();
    drive(1, 1, 7, 1, 1, 9, 0);
    for (int i = 0; i < MUL_STALLS; i++) begin
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mul_stall cycle %0d got %b want 1", i, stall); end
      tick();
    end
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mul_accept got stall %b want 0", stall); end
    tick();
    n_checks++; if (fwd_b_sel !== 2'(MUL_SEL)) begin n_fail++; $display("FAIL mul_fwd_b got %0d want %0d", fwd_b_sel, MUL_SEL); end
    n_checks++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL mul_fwd_a got %0d want 0", fwd_a_sel); end
  endtask

  task automatic test_waw();
    do_reset();
    drive(1, 0, 0, 0, 1, 8, 2);
    tick();
    drive(1, 0, 0, 0, 1, 8, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall cycle %0d got %b want 1", i, stall); end
      tick();
      n_checks++; if (pending_count !== 6'd1) begin n_fail++; $display("FAIL waw_pending cycle %0d got %0d want 1", i, pending_count); end
    end
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL waw_accept got stall %b want 0", stall); end
    tick();
    n_checks++; if (pending_count !== 6'd1) begin n_fail++; $display("FAIL waw_pending_after got %0d want 1", pending_count); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    drive(1, 0, 0, 0, 1, 0, 2);
    tick();
    n_checks++; if (pending_count !== 6'd0) begin n_fail++; $display("FAIL r0_pending got %0d want 0", pending_count); end
    drive(1, 0, 0, 1, 0, 0, 0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall got %b want 0", stall); end
    tick();
    n_checks++; if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL r0_fwd got %0d/%0d want 0/0", fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    drive(1, 0, 0, 0, 1, 3, 0); tick();
    drive(1, 0, 0, 0, 1, 4, 1); tick();
    drive(1, 0, 0, 0, 1, 5, 2); tick();
    n_checks++; if (pending_count !== 6'd3) begin n_fail++; $display("FAIL midop_pending_before got %0d want 3", pending_count); end
    rst = 1'b1;
    drive(1, 0, 0, 0, 1, 9, 0);
    tick();
    rst = 1'b0;
    n_checks++; if (pending_count !== 6'd0) begin n_fail++; $display("FAIL midop_pending_after got %0d want 0", pending_count); end
    drive(1, 5, 4, 1, 0, 0, 0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midop_stall got %b want 0", stall); end
    tick();
    n_checks++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL midop_fwd_a got %0d want 0", fwd_a_sel); end
    n_checks++; if (pending_count !== 6'd0) begin n_fail++; $display("FAIL midop_pending_final got %0d want 0", pending_count); end
  endtask

  task automatic test_random();
    bit exp_st;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3));
      #1;
      exp_st = model_stall();
      n_checks++; if (stall !== exp_st) begin n_fail++; $display("FAIL rand_stall cycle %0d got %b want %b", n, stall, exp_st); end
      tick();
      n_checks++; if (fwd_a_sel !== 2'(exp_a)) begin n_fail++; $display("FAIL rand_fwd_a cycle %0d got %0d want %0d", n, fwd_a_sel, exp_a); end
      n_checks++; if (fwd_b_sel !== 2'(exp_b)) begin n_fail++; $display("FAIL rand_fwd_b cycle %0d got %0d want %0d", n, fwd_b_sel, exp_b); end
      n_checks++; if (pending_count !== 6'(exp_cnt)) begin n_fail++; $display("FAIL rand_pending cycle %0d got %0d want %0d", n, pending_count, exp_cnt); end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      done_at[i] = 0;
      cls_of[i]  = 0;
    end
    test_reset();
    test_back_to_back();
    test_load_use();
    test_mul();
    test_waw();
    test_reg_zero();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
